// File: rtl/rf_pkg.sv
// Shared types and helpers for the register-file write-back queue and its forwarding lookups.
package rf_pkg;

  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);
  localparam int RF_DW    = 32;
  // Upper bound on queue depth seen by the lookup priority encoder.
  localparam int RF_MAXQ  = 32;
  localparam int RF_QIW   = $clog2(RF_MAXQ);

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wb_req_t;

  // Bit position of the highest set bit (age-ranked hits, higher index = newer).
  function automatic logic [RF_QIW-1:0] rf_newest_idx(input logic [RF_MAXQ-1:0] hits);
    logic [RF_QIW-1:0] idx;
    idx = '0;
    for (int i = 0; i < RF_MAXQ; i++) begin
      if (hits[i]) idx = RF_QIW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rf_wb_lookup.sv
// Combinational forwarding search over pending queue entries and the output stage, newest wins.
// RF_ZERO_DROP_EN: address 0 never hits.
module rf_wb_lookup
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  rf_wb_req_t       ents [DEPTH],
  input  logic [DEPTH-1:0] ent_vld,
  input  logic [PW-1:0]    tail,
  input  logic             out_vld,
  input  rf_wb_req_t       out_req,
  input  logic [RF_AW-1:0] addr,
  output logic             hit,
  output logic [RF_DW-1:0] data
);

  logic [RF_MAXQ-1:0] rank_hit;
  logic [RF_DW-1:0]   rank_dat [RF_MAXQ];
  logic [PW-1:0]      idx;
  logic [RF_QIW-1:0]  sel;
  logic               addr_ok;
  logic               out_hit;
  logic               fifo_hit;

`ifdef RF_ZERO_DROP_EN
  assign addr_ok = (addr != '0);
`else
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    rank_hit = '0;
    idx      = '0;
    for (int r = 0; r < RF_MAXQ; r++) rank_dat[r] = '0;
    // Rank r is slot tail+r: the slot at tail is oldest, tail-1 is newest.
    for (int r = 0; r < DEPTH; r++) begin
      idx         = tail + PW'(r);
      rank_hit[r] = addr_ok && ent_vld[idx] && (ents[idx].addr == addr);
      rank_dat[r] = ents[idx].data;
    end
    sel      = rf_newest_idx(rank_hit);
    fifo_hit = |rank_hit;
    out_hit  = addr_ok && out_vld && (out_req.addr == addr);
    hit      = fifo_hit || out_hit;
    if (fifo_hit)     data = rank_dat[sel];
    else if (out_hit) data = out_req.data;
    else              data = '0;
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order write-back FIFO driving the register file WR/WD/WE port; push-to-WE is one cycle when empty.
// IN_READY drops at DEPTH entries, HOLD stalls draining; RF_ZERO_DROP_EN discards writes to r0.
module rf_writeback_queue
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [AW-1:0]          IN_WR,
  input  logic [DW-1:0]          IN_WD,
  input  logic                   HOLD,
  output logic [AW-1:0]          WR,
  output logic [DW-1:0]          WD,
  output logic                   WE,
  input  logic [AW-1:0]          LK1_ADDR,
  output logic                   LK1_HIT,
  output logic [DW-1:0]          LK1_DATA,
  input  logic [AW-1:0]          LK2_ADDR,
  output logic                   LK2_HIT,
  output logic [DW-1:0]          LK2_DATA,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int PW = $clog2(DEPTH);

  rf_wb_req_t       mem [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             push;
  logic             enq;
  logic             pop;
  rf_wb_req_t       out_req;

  assign IN_READY = (COUNT < (PW+1)'(DEPTH));
  assign push     = IN_VALID && IN_READY;
  assign pop      = (COUNT != '0) && !HOLD;
  assign out_req  = '{addr: WR, data: WD};

`ifdef RF_ZERO_DROP_EN
  // Writes to the hardwired zero register complete the handshake but never queue.
  assign enq = push && (IN_WR != '0);
`else
  assign enq = push;
`endif

  always_ff @(posedge CLK) begin
    if (enq) mem[tail] <= '{addr: IN_WR, data: IN_WD};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head    <= '0;
      tail    <= '0;
      COUNT   <= '0;
      ent_vld <= '0;
      WE      <= 1'b0;
      WR      <= '0;
      WD      <= '0;
    end else begin
      WE <= pop;
      if (pop) begin
        WR            <= mem[head].addr;
        WD            <= mem[head].data;
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      // Slots at head and tail only coincide when empty or full, so these never collide.
      if (enq) begin
        ent_vld[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (enq && !pop)      COUNT <= COUNT + 1'b1;
      else if (!enq && pop) COUNT <= COUNT - 1'b1;
    end
  end

  rf_wb_lookup #(.DEPTH(DEPTH), .PW(PW)) u_lk1 (
    .ents    (mem),
    .ent_vld (ent_vld),
    .tail    (tail),
    .out_vld (WE),
    .out_req (out_req),
    .addr    (LK1_ADDR),
    .hit     (LK1_HIT),
    .data    (LK1_DATA)
  );

  rf_wb_lookup #(.DEPTH(DEPTH), .PW(PW)) u_lk2 (
    .ents    (mem),
    .ent_vld (ent_vld),
    .tail    (tail),
    .out_vld (WE),
    .out_req (out_req),
    .addr    (LK2_ADDR),
    .hit     (LK2_HIT),
    .data    (LK2_DATA)
  );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: constant-expectation table, directed corner sequences, random vs queue model.
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [4:0]  IN_WR;
  logic [31:0] IN_WD;
  logic        HOLD;
  logic [4:0]  WR;
  logic [31:0] WD;
  logic        WE;
  logic [4:0]  LK1_ADDR;
  logic        LK1_HIT;
  logic [31:0] LK1_DATA;
  logic [4:0]  LK2_ADDR;
  logic        LK2_HIT;
  logic [31:0] LK2_DATA;
  logic [2:0]  COUNT;

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_WR(IN_WR), .IN_WD(IN_WD), .HOLD(HOLD), .WR(WR), .WD(WD), .WE(WE),
    .LK1_ADDR(LK1_ADDR), .LK1_HIT(LK1_HIT), .LK1_DATA(LK1_DATA),
    .LK2_ADDR(LK2_ADDR), .LK2_HIT(LK2_HIT), .LK2_DATA(LK2_DATA),
    .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pending writes in arrival order plus the last write presented to the register file.
  typedef struct packed { bit [4:0] a; bit [31:0] d; } ent_t;
  ent_t      mq[$];
  bit        m_we;
  bit [4:0]  m_wr;
  bit [31:0] m_wd;

  typedef struct packed {
    bit vld; bit [4:0] wr; bit [31:0] wd; bit hold;
    int e_cnt; bit e_we; bit [4:0] e_wr; bit [31:0] e_wd; bit e_rdy;
  } vec_t;
  vec_t tbl [14];

  function automatic vec_t mk(bit vld, bit [4:0] wr, bit [31:0] wd, bit hold,
                              int e_cnt, bit e_we, bit [4:0] e_wr, bit [31:0] e_wd, bit e_rdy);
    vec_t v;
    v = '{vld: vld, wr: wr, wd: wd, hold: hold, e_cnt: e_cnt, e_we: e_we,
          e_wr: e_wr, e_wd: e_wd, e_rdy: e_rdy};
    return v;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_we = 1'b0;
    m_wr = '0;
    m_wd = '0;
  endfunction

  function automatic void mlook(input bit [4:0] a, output bit h, output bit [31:0] d);
    h = 1'b0;
    d = '0;
`ifdef RF_ZERO_DROP_EN
    if (a == 5'd0) return;
`endif
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == a) begin
        h = 1'b1;
        d = mq[i].d;
        return;
      end
    end
    if (m_we && m_wr == a) begin
      h = 1'b1;
      d = m_wd;
    end
  endfunction

  task automatic drive(bit vld, bit [4:0] wr, bit [31:0] wd, bit hold);
    IN_VALID = vld;
    IN_WR    = wr;
    IN_WD    = wd;
    HOLD     = hold;
  endtask

  // Advances one clock with the current inputs, updating the model, and returns at the falling edge.
  task automatic tick();
    bit   acc, pop, keep;
    ent_t e;
    acc  = IN_VALID && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && !HOLD;
    keep = 1'b1;
`ifdef RF_ZERO_DROP_EN
    if (IN_WR == 5'd0) keep = 1'b0;
`endif
    @(posedge CLK);
    if (pop) begin
      e    = mq.pop_front();
      m_we = 1'b1;
      m_wr = e.a;
      m_wd = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (acc && keep) mq.push_back(ent_t'{a: IN_WR, d: IN_WD});
    @(negedge CLK);
  endtask

  task automatic check_state(string tag, int cnt, bit we, bit [4:0] wr, bit [31:0] wd, bit rdy);
    chk({tag, "_count"}, 32'(COUNT), 32'(cnt));
    chk({tag, "_we"},    32'(WE),    32'(we));
    chk({tag, "_wr"},    32'(WR),    32'(wr));
    chk({tag, "_wd"},    WD,         wd);
    chk({tag, "_ready"}, 32'(IN_READY), 32'(rdy));
  endtask

  task automatic check_model(string tag);
    check_state(tag, mq.size(), m_we, m_wr, m_wd, mq.size() < DEPTH);
  endtask

  task automatic lk(string tag, bit [4:0] a1, bit [4:0] a2);
    bit        h;
    bit [31:0] d;
    LK1_ADDR = a1;
    LK2_ADDR = a2;
    #1;
    mlook(a1, h, d);
    chk({tag, "_lk1_hit"},  32'(LK1_HIT), 32'(h));
    chk({tag, "_lk1_data"}, LK1_DATA,     d);
    mlook(a2, h, d);
    chk({tag, "_lk2_hit"},  32'(LK2_HIT), 32'(h));
    chk({tag, "_lk2_data"}, LK2_DATA,     d);
  endtask

  task automatic lk_const(string tag, bit [4:0] a1, bit h1, bit [31:0] d1,
                          bit [4:0] a2, bit h2, bit [31:0] d2);
    LK1_ADDR = a1;
    LK2_ADDR = a2;
    #1;
    chk({tag, "_lk1_hit"},  32'(LK1_HIT), 32'(h1));
    chk({tag, "_lk1_data"}, LK1_DATA,     d1);
    chk({tag, "_lk2_hit"},  32'(LK2_HIT), 32'(h2));
    chk({tag, "_lk2_data"}, LK2_DATA,     d2);
  endtask

  initial begin
    // Single write, then fill under HOLD, stalled 5th request, and in-order drain.
    tbl[0]  = mk(1, 5, 32'hA5, 0, 1, 0, 0, 32'h0,  1);
    tbl[1]  = mk(0, 0, 32'h0,  0, 0, 1, 5, 32'hA5, 1);
    tbl[2]  = mk(0, 0, 32'h0,  0, 0, 0, 5, 32'hA5, 1);
    tbl[3]  = mk(1, 1, 32'd10, 1, 1, 0, 5, 32'hA5, 1);
    tbl[4]  = mk(1, 2, 32'd20, 1, 2, 0, 5, 32'hA5, 1);
    tbl[5]  = mk(1, 3, 32'd30, 1, 3, 0, 5, 32'hA5, 1);
    tbl[6]  = mk(1, 4, 32'd40, 1, 4, 0, 5, 32'hA5, 0);
    tbl[7]  = mk(1, 9, 32'd99, 1, 4, 0, 5, 32'hA5, 0);
    tbl[8]  = mk(1, 9, 32'd99, 0, 3, 1, 1, 32'd10, 1);
    tbl[9]  = mk(1, 9, 32'd99, 0, 3, 1, 2, 32'd20, 1);
    tbl[10] = mk(0, 0, 32'h0,  0, 2, 1, 3, 32'd30, 1);
    tbl[11] = mk(0, 0, 32'h0,  0, 1, 1, 4, 32'd40, 1);
    tbl[12] = mk(0, 0, 32'h0,  0, 0, 1, 9, 32'd99, 1);
    tbl[13] = mk(0, 0, 32'h0,  0, 0, 0, 9, 32'd99, 1);

    RST_N = 1'b1;
    drive(0, 0, 0, 0);
    LK1_ADDR = '0;
    LK2_ADDR = '0;
    model_reset();
    #1 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check_state("reset", 0, 0, 0, 0, 1);
    RST_N = 1'b1;

    // Reset asserted mid-drain with entries still queued.
    drive(1, 3, 32'h33, 1); tick();
    drive(1, 4, 32'h44, 1); tick();
    drive(1, 6, 32'h66, 1); tick();
    drive(0, 0, 0, 0);      tick();
    check_state("t1_pre", 2, 1, 3, 32'h33, 1);
    #2 RST_N = 1'b0;
    #1;
    check_state("t1_async", 0, 0, 0, 0, 1);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int a = 0; a < 32; a++) lk_const("t1_clear", 5'(a), 0, 0, 5'(31 - a), 0, 0);
    @(negedge CLK);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].vld, tbl[i].wr, tbl[i].wd, tbl[i].hold);
      tick();
      check_state($sformatf("tbl%0d", i), tbl[i].e_cnt, tbl[i].e_we, tbl[i].e_wr,
                  tbl[i].e_wd, tbl[i].e_rdy);
    end

    // Forwarding priority: newest queued write beats older one and the output stage.
    drive(1, 7, 32'd1, 1); tick();
    drive(1, 7, 32'd2, 1); tick();
    drive(0, 0, 0, 1);
    lk_const("t4_q", 7, 1, 32'd2, 8, 0, 0);
    drive(0, 0, 0, 0); tick();
    lk_const("t4_outq", 7, 1, 32'd2, 8, 0, 0);
    tick();
    lk_const("t4_out", 7, 1, 32'd2, 8, 0, 0);
    tick();
    lk_const("t4_done", 7, 0, 0, 8, 0, 0);

    // Simultaneous push and pop at two entries.
    drive(1, 10, 32'h100, 1); tick();
    drive(1, 11, 32'h110, 1); tick();
    drive(1, 12, 32'h120, 0); tick();
    check_state("t5_pp", 2, 1, 10, 32'h100, 1);
    drive(0, 0, 0, 0); tick();
    check_state("t5_d1", 1, 1, 11, 32'h110, 1);
    tick();
    check_state("t5_d2", 0, 1, 12, 32'h120, 1);
    tick();
    check_state("t5_d3", 0, 0, 12, 32'h120, 1);

    // Writes to register 0.
    drive(1, 0, 32'hFF, 0);
    #1 chk("t6_ready", 32'(IN_READY), 32'd1);
    tick();
    drive(0, 0, 0, 0);
`ifdef RF_ZERO_DROP_EN
    check_state("t6_drop", 0, 0, 12, 32'h120, 1);
    tick();
    check_state("t6_nowe", 0, 0, 12, 32'h120, 1);
    lk_const("t6_lk0", 0, 0, 0, 0, 0, 0);
`else
    check_state("t6_q", 1, 0, 12, 32'h120, 1);
    lk_const("t6_lk0", 0, 1, 32'hFF, 12, 0, 0);
    tick();
    check_state("t6_commit", 0, 1, 0, 32'hFF, 1);
`endif
    tick();

    // Randomized traffic against the queue model, small address range for collisions.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 3);
      tick();
      check_model("rnd");
      lk("rnd", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
